rc4_phase_sequencer: RTL and testbench
======================================

Name: rc4_phase_sequencer

Overview:
Top-level scheduler for the RC4 engine. Runs the three phases in order (S-memory init, key-schedule shuffle, decrypt) using start/finish handshakes. Owns the single-port S-memory port (address, data, wren) and grants it to exactly one phase FSM at a time. Latches the secret key for the run, watches each phase for hangs, and reports busy/done/error to the board top.

Parameters:
ADDR_W, 8, S-memory address width
DATA_W, 8, S-memory data width
KEY_W, 24, secret key width
TIMEOUT, 4095, maximum cycles allowed per phase before error (at most 2^16-1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled each cycle
abort  in  1  synchronous abort
secret_key  in  KEY_W  key, latched when start is accepted
key_out  out  KEY_W  latched key, fed to shuffle FSM
init_start / shuffle_start / decrypt_start  out  1 each  one-cycle phase start pulses
init_finish / shuffle_finish / decrypt_finish  in  1 each  phase completion (level or pulse)
init_addr, shuffle_addr, decrypt_addr  in  ADDR_W each  requester addresses
init_data, shuffle_data, decrypt_data  in  DATA_W each  requester write data
init_wren, shuffle_wren, decrypt_wren  in  1 each  requester write enables
mem_address  out  ADDR_W  to S-memory
mem_data  out  DATA_W  to S-memory
mem_wren  out  1  to S-memory
state  out  3  IDLE=0, INIT=1, SHUFFLE=2, DECRYPT=3, DONE=4, ERROR=5
busy  out  1  high in INIT, SHUFFLE or DECRYPT
done  out  1  high in DONE
error  out  1  high in ERROR

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, all *_start=0, key_out=0, timeout counter=0. Combinational outputs follow from IDLE: busy/done/error=0, mem_* = 0.
- Start acceptance: start=1 with abort=0 in IDLE, DONE or ERROR -> next state INIT, key_out<=secret_key, done/error clear. start in any other state is ignored; key_out does not change.
- Phase entry: on the clock edge that enters INIT, SHUFFLE or DECRYPT, the matching *_start is registered high for exactly one cycle. The timeout counter clears to 0.
- Phase exit: the matching *_finish is sampled from the cycle after the start pulse onward. A finish that is high during the start-pulse cycle is ignored, so a stale level from the previous run is never taken. INIT+init_finish -> SHUFFLE; SHUFFLE+shuffle_finish -> DECRYPT; DECRYPT+decrypt_finish -> DONE. A finish input of a non-active phase has no effect.
- Timeout: the counter increments each cycle in an active phase. If the counter reaches TIMEOUT with no finish -> ERROR. If finish and timeout occur in the same cycle, finish wins.
- Abort: abort=1 in any state -> IDLE on the next edge and no start pulse is issued. mem_wren is forced to 0 combinationally in the same cycle. If abort coincides with start or finish, abort wins.
- Memory arbitration (combinational from the state register):
  - INIT: mem_* = init_*.
  - SHUFFLE: mem_* = shuffle_*.
  - DECRYPT: mem_* = decrypt_*.
  - IDLE, DONE, ERROR: address=0, data=0, wren=0.
  - Write enables from non-owners never reach mem_wren.
- Latency: start accepted -> init_start high 1 cycle later. Finish sampled -> next phase start pulse on the following edge. Mux path has zero latency.
- DONE and ERROR are held until the next accepted start or an abort.

Test Plan:
- Nominal run: key=24'h000249, start pulse; stub finishes at 256, 768 and 50 cycles -> state 1->2->3->4, each *_start high exactly 1 cycle, done=1, key_out=24'h000249.
- Arbitration: in SHUFFLE drive init_wren=1 and shuffle_wren=0 with shuffle_addr=8'h3C -> mem_wren=0, mem_address=8'h3C. With decrypt_wren=1 in IDLE -> mem_wren=0.
- Timeout: TIMEOUT=15, shuffle_finish never asserts -> ERROR exactly 15 cycles after shuffle_start, error=1, mem_wren=0. A new start -> INIT with error cleared.
- Stale finish: init_finish held high from reset, then start -> init_finish ignored during the init_start cycle; transition to SHUFFLE on the next cycle.
- Abort mid-DECRYPT with decrypt_wren=1 -> mem_wren=0 in the same cycle, state=IDLE next cycle, no start pulses. Abort with start in the same cycle in IDLE -> stays IDLE.
- Async reset asserted mid-SHUFFLE between clock edges -> state=0, mem_wren=0, key_out=0 immediately; a start after reset release runs normally.

Source files
------------

// File: rtl/rc4_phase_sequencer_if.sv
// Phase handshake, requester buses and S-memory port of the RC4 scheduler.
// master = the sequencer; slave = the phase FSMs and S-memory.
interface rc4_phase_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int KEY_W  = 24
);
  logic [KEY_W-1:0]  key_out;
  logic              init_start;
  logic              shuffle_start;
  logic              decrypt_start;
  logic              init_finish;
  logic              shuffle_finish;
  logic              decrypt_finish;
  logic [ADDR_W-1:0] init_addr;
  logic [ADDR_W-1:0] shuffle_addr;
  logic [ADDR_W-1:0] decrypt_addr;
  logic [DATA_W-1:0] init_data;
  logic [DATA_W-1:0] shuffle_data;
  logic [DATA_W-1:0] decrypt_data;
  logic              init_wren;
  logic              shuffle_wren;
  logic              decrypt_wren;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;

  modport master (
    output key_out, init_start, shuffle_start, decrypt_start,
    output mem_address, mem_data, mem_wren,
    input  init_finish, shuffle_finish, decrypt_finish,
    input  init_addr, shuffle_addr, decrypt_addr,
    input  init_data, shuffle_data, decrypt_data,
    input  init_wren, shuffle_wren, decrypt_wren
  );

  modport slave (
    input  key_out, init_start, shuffle_start, decrypt_start,
    input  mem_address, mem_data, mem_wren,
    output init_finish, shuffle_finish, decrypt_finish,
    output init_addr, shuffle_addr, decrypt_addr,
    output init_data, shuffle_data, decrypt_data,
    output init_wren, shuffle_wren, decrypt_wren
  );
endinterface

// File: rtl/rc4_phase_sequencer.sv
// RC4 top scheduler: runs init -> shuffle -> decrypt, owns the S-memory port,
// latches the key and traps phases that exceed TIMEOUT cycles.
module rc4_phase_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int KEY_W   = 24,
  parameter int TIMEOUT = 4095
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [KEY_W-1:0]       secret_key,
  rc4_phase_sequencer_if.master  bus,
  output logic [2:0]             state,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHUFFLE = 3'd2,
    S_DECRYPT = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             init_start_q, init_start_d;
  logic             shuffle_start_q, shuffle_start_d;
  logic             decrypt_start_q, decrypt_start_d;

  logic             phase_fin;
  logic             fin_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      key_q           <= '0;
      init_start_q    <= 1'b0;
      shuffle_start_q <= 1'b0;
      decrypt_start_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      key_q           <= key_d;
      init_start_q    <= init_start_d;
      shuffle_start_q <= shuffle_start_d;
      decrypt_start_q <= decrypt_start_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    key_d     = key_q;
    phase_fin = 1'b0;
    unique case (state_q)
      S_INIT:    phase_fin = bus.init_finish;
      S_SHUFFLE: phase_fin = bus.shuffle_finish;
      S_DECRYPT: phase_fin = bus.decrypt_finish;
      default:   phase_fin = 1'b0;
    endcase
    // A finish level seen while the start pulse is still out is left over from a previous run.
    fin_ok = phase_fin & ~(init_start_q | shuffle_start_q | decrypt_start_q);

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_INIT, S_SHUFFLE, S_DECRYPT: begin
          if (fin_ok) begin
            unique case (state_q)
              S_INIT:    state_d = S_SHUFFLE;
              S_SHUFFLE: state_d = S_DECRYPT;
              default:   state_d = S_DONE;
            endcase
          end else if (cnt_q == TO_LAST) begin
            state_d = S_ERROR;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          if (start) begin
            state_d = S_INIT;
            key_d   = secret_key;
          end
        end
      endcase
    end

    init_start_d    = (state_d == S_INIT)    && (state_q != S_INIT);
    shuffle_start_d = (state_d == S_SHUFFLE) && (state_q != S_SHUFFLE);
    decrypt_start_d = (state_d == S_DECRYPT) && (state_q != S_DECRYPT);
  end

  always_comb begin
    state             = state_q;
    busy              = 1'b0;
    done              = 1'b0;
    error             = 1'b0;
    bus.key_out       = key_q;
    bus.init_start    = init_start_q;
    bus.shuffle_start = shuffle_start_q;
    bus.decrypt_start = decrypt_start_q;
    bus.mem_address   = '0;
    bus.mem_data      = '0;
    bus.mem_wren      = 1'b0;
    unique case (state_q)
      S_INIT: begin
        busy            = 1'b1;
        bus.mem_address = bus.init_addr;
        bus.mem_data    = bus.init_data;
        bus.mem_wren    = bus.init_wren;
      end
      S_SHUFFLE: begin
        busy            = 1'b1;
        bus.mem_address = bus.shuffle_addr;
        bus.mem_data    = bus.shuffle_data;
        bus.mem_wren    = bus.shuffle_wren;
      end
      S_DECRYPT: begin
        busy            = 1'b1;
        bus.mem_address = bus.decrypt_addr;
        bus.mem_data    = bus.decrypt_data;
        bus.mem_wren    = bus.decrypt_wren;
      end
      S_DONE:  done  = 1'b1;
      S_ERROR: error = 1'b1;
      default: ;
    endcase
    if (abort) bus.mem_wren = 1'b0;
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Bench: two sequencers (TIMEOUT 4095 and 15) share one directed stimulus and are
// checked every cycle against a phase/age model, plus literal spot checks.
module tb_rc4_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] secret_key = '0;
  logic        init_finish = 1'b0, shuffle_finish = 1'b0, decrypt_finish = 1'b0;
  logic [7:0]  init_addr = '0, shuffle_addr = '0, decrypt_addr = '0;
  logic [7:0]  init_data = '0, shuffle_data = '0, decrypt_data = '0;
  logic        init_wren = 1'b0, shuffle_wren = 1'b0, decrypt_wren = 1'b0;

  logic [2:0]  st   [2];
  logic        bsy  [2];
  logic        dn   [2];
  logic        er   [2];
  logic [7:0]  m_addr [2];
  logic [7:0]  m_data [2];
  logic        m_wren [2];
  logic [23:0] k_out  [2];
  logic        s_ini  [2];
  logic        s_shf  [2];
  logic        s_dec  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rc4_phase_sequencer_if #(.ADDR_W(8), .DATA_W(8), .KEY_W(24)) bus ();
    assign bus.init_finish    = init_finish;
    assign bus.shuffle_finish = shuffle_finish;
    assign bus.decrypt_finish = decrypt_finish;
    assign bus.init_addr      = init_addr;
    assign bus.shuffle_addr   = shuffle_addr;
    assign bus.decrypt_addr   = decrypt_addr;
    assign bus.init_data      = init_data;
    assign bus.shuffle_data   = shuffle_data;
    assign bus.decrypt_data   = decrypt_data;
    assign bus.init_wren      = init_wren;
    assign bus.shuffle_wren   = shuffle_wren;
    assign bus.decrypt_wren   = decrypt_wren;
    assign m_addr[g] = bus.mem_address;
    assign m_data[g] = bus.mem_data;
    assign m_wren[g] = bus.mem_wren;
    assign k_out[g]  = bus.key_out;
    assign s_ini[g]  = bus.init_start;
    assign s_shf[g]  = bus.shuffle_start;
    assign s_dec[g]  = bus.decrypt_start;

    rc4_phase_sequencer #(
      .ADDR_W(8), .DATA_W(8), .KEY_W(24), .TIMEOUT(g == 0 ? 4095 : 15)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .secret_key (secret_key),
      .bus        (bus),
      .state      (st[g]),
      .busy       (bsy[g]),
      .done       (dn[g]),
      .error      (er[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase number, cycles spent in the phase (0 = pulse cycle), latched key.
  int          ph   [2] = '{0, 0};
  int          age  [2] = '{0, 0};
  logic [23:0] mkey [2] = '{24'h0, 24'h0};
  int          tmo  [2] = '{4095, 15};

  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        ph[d] <= 0; age[d] <= 0; mkey[d] <= '0;
      end else if (abort) begin
        ph[d] <= 0; age[d] <= 0;
      end else if (ph[d] == 0 || ph[d] >= 4) begin
        if (start) begin
          ph[d] <= 1; age[d] <= 0; mkey[d] <= secret_key;
        end
      end else begin
        if (age[d] > 0 && ((ph[d] == 1 && init_finish) || (ph[d] == 2 && shuffle_finish) ||
                           (ph[d] == 3 && decrypt_finish))) begin
          ph[d] <= ph[d] + 1; age[d] <= 0;
        end else if (age[d] + 1 >= tmo[d]) begin
          ph[d] <= 5; age[d] <= 0;
        end else begin
          age[d] <= age[d] + 1;
        end
      end
    end
  end

  logic [7:0] ea, ed;
  logic       ew;
  always @(negedge clk) begin
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        ea = 8'h0; ed = 8'h0; ew = 1'b0;
        if (ph[d] == 1) begin ea = init_addr;    ed = init_data;    ew = init_wren;    end
        if (ph[d] == 2) begin ea = shuffle_addr; ed = shuffle_data; ew = shuffle_wren; end
        if (ph[d] == 3) begin ea = decrypt_addr; ed = decrypt_data; ew = decrypt_wren; end
        if (abort) ew = 1'b0;
        chk($sformatf("dut%0d state", d), 32'(st[d]), 32'(ph[d]));
        chk($sformatf("dut%0d flags", d), {29'd0, bsy[d], dn[d], er[d]},
            {29'd0, ph[d] >= 1 && ph[d] <= 3, ph[d] == 4, ph[d] == 5});
        chk($sformatf("dut%0d starts", d), {29'd0, s_ini[d], s_shf[d], s_dec[d]},
            {29'd0, ph[d] == 1 && age[d] == 0, ph[d] == 2 && age[d] == 0,
             ph[d] == 3 && age[d] == 0});
        chk($sformatf("dut%0d mem", d), {15'd0, m_wren[d], m_data[d], m_addr[d]},
            {15'd0, ew, ed, ea});
        chk($sformatf("dut%0d key", d), 32'(k_out[d]), 32'(mkey[d]));
      end
    end
  end

  int n_is = 0, n_ss = 0, n_ds = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (s_ini[0]) n_is <= n_is + 1;
      if (s_shf[0]) n_ss <= n_ss + 1;
      if (s_dec[0]) n_ds <= n_ds + 1;
    end
  end

  bit   pat_en = 1'b1;
  int   pat = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (pat_en) begin
      pat++;
      init_addr    = 8'(pat);        init_data    = 8'(pat * 3);
      shuffle_addr = 8'(~pat);       shuffle_data = 8'(pat + 8'h40);
      decrypt_addr = 8'(pat ^ 8'h5A); decrypt_data = 8'(pat * 7);
      init_wren    = pat[0];
      shuffle_wren = pat[1];
      decrypt_wren = pat[0] ^ pat[2];
    end
  endtask

  task automatic finish_after(input int which, input int n);
    repeat (n) cyc();
    if (which == 0) init_finish = 1'b1;
    if (which == 1) shuffle_finish = 1'b1;
    if (which == 2) decrypt_finish = 1'b1;
    cyc();
    init_finish = 1'b0; shuffle_finish = 1'b0; decrypt_finish = 1'b0;
  endtask

  task automatic go(input logic [23:0] key);
    secret_key = key; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  initial begin
    int k;
    init_finish = 1'b1;
    repeat (3) cyc();
    chk("reset state", 32'(st[0]), 32'd0);
    chk("reset key", 32'(k_out[0]), 32'd0);
    chk("reset starts", {29'd0, s_ini[0], s_shf[0], s_dec[0]}, 32'd0);
    chk("reset flags", {29'd0, bsy[0], dn[0], er[0]}, 32'd0);
    chk("reset mem", {15'd0, m_wren[0], m_data[0], m_addr[0]}, 32'd0);
    reset_n = 1'b1;
    cyc();

    // Stale init_finish held from reset
    go(24'hA5A5A5);
    chk("stale pulse state", 32'(st[0]), 32'd1);
    chk("stale init_start", 32'(s_ini[0]), 32'd1);
    cyc();
    chk("stale ignored", 32'(st[0]), 32'd1);
    cyc();
    chk("stale then shuffle", 32'(st[0]), 32'd2);
    init_finish = 1'b0;
    do_abort();

    // Nominal run
    n_is = 0; n_ss = 0; n_ds = 0;
    go(24'h000249);
    finish_after(0, 256);
    chk("nominal shuffle", 32'(st[0]), 32'd2);
    repeat (10) cyc();
    pat_en = 1'b0;
    init_wren = 1'b1; shuffle_wren = 1'b0; shuffle_addr = 8'h3C;
    #1;
    chk("arb owner addr", 32'(m_addr[0]), 32'h3C);
    chk("arb non-owner wren", 32'(m_wren[0]), 32'd0);
    pat_en = 1'b1;
    finish_after(1, 758);
    chk("nominal decrypt", 32'(st[0]), 32'd3);
    finish_after(2, 50);
    chk("nominal done state", 32'(st[0]), 32'd4);
    chk("nominal done flag", 32'(dn[0]), 32'd1);
    chk("nominal key", 32'(k_out[0]), 32'h000249);
    chk("init_start count", 32'(n_is), 32'd1);
    chk("shuffle_start count", 32'(n_ss), 32'd1);
    chk("decrypt_start count", 32'(n_ds), 32'd1);
    chk("short timeout errored", 32'(st[1]), 32'd5);

    do_abort();
    pat_en = 1'b0; decrypt_wren = 1'b1;
    #1;
    chk("idle wren blocked", 32'(m_wren[0]), 32'd0);
    pat_en = 1'b1;

    // Shuffle timeout on the TIMEOUT=15 instance
    go(24'h123456);
    finish_after(0, 3);
    chk("to shuffle entered", 32'(s_shf[1]), 32'd1);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      cyc();
      if (st[1] == 3'd5) k = i;
    end
    chk("timeout cycles", 32'(k), 32'd15);
    chk("timeout error flag", 32'(er[1]), 32'd1);
    chk("timeout mem_wren", 32'(m_wren[1]), 32'd0);
    go(24'h00BEEF);
    chk("restart from error", 32'(st[1]), 32'd1);
    chk("error cleared", 32'(er[1]), 32'd0);
    chk("start ignored in shuffle", 32'(k_out[0]), 32'h123456);
    do_abort();

    // Abort mid-decrypt
    go(24'h0F0F0F);
    finish_after(0, 4);
    finish_after(1, 4);
    chk("abort pre decrypt", 32'(st[0]), 32'd3);
    pat_en = 1'b0; decrypt_wren = 1'b1;
    cyc();
    abort = 1'b1;
    #1;
    chk("abort wren same cycle", 32'(m_wren[0]), 32'd0);
    cyc();
    abort = 1'b0;
    chk("abort to idle", 32'(st[0]), 32'd0);
    repeat (3) cyc();
    abort = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0;
    chk("abort beats start", 32'(st[0]), 32'd0);
    chk("abort no pulse", 32'(s_ini[0]), 32'd0);
    pat_en = 1'b1;

    // Async reset mid-shuffle
    go(24'h777777);
    finish_after(0, 4);
    pat_en = 1'b0; shuffle_wren = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk("async reset state", 32'(st[0]), 32'd0);
    chk("async reset wren", 32'(m_wren[0]), 32'd0);
    chk("async reset key", 32'(k_out[0]), 32'd0);
    cyc();
    reset_n = 1'b1;
    pat_en = 1'b1;
    cyc();
    go(24'h0000AB);
    finish_after(0, 5);
    finish_after(1, 6);
    finish_after(2, 7);
    chk("post reset done", 32'(st[0]), 32'd4);
    chk("post reset key", 32'(k_out[0]), 32'h0000AB);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
